// File: rtl/nucore_pkg.sv
// Shared core definitions: datapath widths, control-field layout and the
// memory/writeback control bundle carried down the pipeline.
package nucore_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;

    // ctl_in layout: {branch_eq, branch_ne, regwrite, memread, memwrite, memtoreg}
    localparam int unsigned CTL_W       = 6;
    localparam int unsigned CTL_BEQ_BIT = 5;
    localparam int unsigned CTL_BNE_BIT = 4;

    // Memory/writeback control fields forwarded to MEM, lower bits of ctl_in.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } mem_ctl_t;

    localparam int unsigned MEM_CTL_W = $bits(mem_ctl_t);

endpackage

// File: rtl/branch_resolve.sv
// Combinational conditional-branch resolver (beq/bne).
// Ports:
//   zero      in   ALU zero flag
//   beq, bne  in   branch-on-equal / branch-on-not-equal controls
//   pc_plus4  in   PC+4 of the branch instruction
//   offset    in   sign-extended word offset
//   taken_c   out  branch condition holds
//   target_c  out  pc_plus4 + offset*4, wrapping at DATA_W bits
module branch_resolve #(
    parameter int unsigned DATA_W = nucore_pkg::DATA_W
) (
    input  logic              zero,
    input  logic              beq,
    input  logic              bne,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] offset,
    output logic              taken_c,
    output logic [DATA_W-1:0] target_c
);

    // Both controls set makes the condition trivially true.
    assign taken_c  = (beq & zero) | (bne & ~zero);

    // Word offset to byte offset; top bits fall off and the sum wraps.
    assign target_c = pc_plus4 + DATA_W'(offset << 2);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: captures ALU result and forwarded fields behind
// a valid/ready handshake with a two-slot (main + skid) buffer so that
// in_ready comes straight from a flop, and resolves beq/bne at accept.
// Ports:
//   clk, reset            clock, async active-high reset
//   flush                 squash held entries and the incoming beat
//   in_valid / in_ready   EX-side handshake (in_ready registered)
//   alu_result, alu_zero, store_data, pc_plus4, branch_offset, dest_reg,
//   ctl_in                EX-side payload
//   out_valid / out_ready MEM-side handshake
//   out_result, out_store_data, out_dest_reg, out_ctl  MEM-side payload
//   branch_taken          one-cycle pulse after a taken branch is accepted
//   branch_target         target address, valid with branch_taken
module ex_mem_stage #(
    parameter int unsigned DATA_W = nucore_pkg::DATA_W,
    parameter int unsigned REG_W  = nucore_pkg::REG_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic                          alu_zero,
    input  logic [DATA_W-1:0]             store_data,
    input  logic [DATA_W-1:0]             pc_plus4,
    input  logic [DATA_W-1:0]             branch_offset,
    input  logic [REG_W-1:0]              dest_reg,
    input  logic [nucore_pkg::CTL_W-1:0]  ctl_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_result,
    output logic [DATA_W-1:0]             out_store_data,
    output logic [REG_W-1:0]              out_dest_reg,
    output logic [nucore_pkg::MEM_CTL_W-1:0] out_ctl,
    output logic                          branch_taken,
    output logic [DATA_W-1:0]             branch_target
);

    import nucore_pkg::*;

    // Main slot (drives out_*) and skid slot.
    logic              main_valid;
    mem_ctl_t          main_ctl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_result;
    logic [DATA_W-1:0] skid_store_data;
    logic [REG_W-1:0]  skid_dest_reg;
    mem_ctl_t          skid_ctl;
    logic              in_ready_q;

    logic              accept_c;
    logic              drain_c;
    logic              main_free_c;
    logic              taken_c;
    logic [DATA_W-1:0] target_c;
    mem_ctl_t          in_ctl_c;

    assign in_ctl_c    = mem_ctl_t'(ctl_in[MEM_CTL_W-1:0]);
    assign accept_c    = in_valid & in_ready_q & ~flush;
    assign drain_c     = main_valid & out_ready;
    // Main can take a new entry this edge if empty or being consumed.
    assign main_free_c = ~main_valid | drain_c;

    branch_resolve #(
        .DATA_W (DATA_W)
    ) u_branch_resolve (
        .zero     (alu_zero),
        .beq      (ctl_in[CTL_BEQ_BIT]),
        .bne      (ctl_in[CTL_BNE_BIT]),
        .pc_plus4 (pc_plus4),
        .offset   (branch_offset),
        .taken_c  (taken_c),
        .target_c (target_c)
    );

    // Branch pulse: only beats actually accepted can produce it, so a beat
    // presented during flush never pulses; a pulse already registered still shows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_taken <= accept_c & taken_c;
            if (accept_c) begin
                branch_target <= target_c;
            end
        end
    end

    // Valid flags and in_ready; in_ready tracks the next skid_valid inverted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (main_free_c) begin
            // in_ready is low whenever skid holds data, so accept and skid
            // refill cannot coincide here.
            main_valid <= skid_valid | accept_c;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (accept_c) begin
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end

    // Main slot data: refilled from skid first (oldest), else from input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result     <= '0;
            out_store_data <= '0;
            out_dest_reg   <= '0;
            main_ctl       <= '0;
        end else if (!flush && main_free_c) begin
            if (skid_valid) begin
                out_result     <= skid_result;
                out_store_data <= skid_store_data;
                out_dest_reg   <= skid_dest_reg;
                main_ctl       <= skid_ctl;
            end else if (accept_c) begin
                out_result     <= alu_result;
                out_store_data <= store_data;
                out_dest_reg   <= dest_reg;
                main_ctl       <= in_ctl_c;
            end
        end
    end

    // Skid slot data: loads only when an accept finds main held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_result     <= '0;
            skid_store_data <= '0;
            skid_dest_reg   <= '0;
            skid_ctl        <= '0;
        end else if (accept_c && !main_free_c) begin
            skid_result     <= alu_result;
            skid_store_data <= store_data;
            skid_dest_reg   <= dest_reg;
            skid_ctl        <= in_ctl_c;
        end
    end

    assign out_valid = main_valid;
    assign out_ctl   = main_ctl;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [4:0]  dest_reg;
    logic [5:0]  ctl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest_reg;
    logic [3:0]  out_ctl;
    logic        branch_taken;
    logic [31:0] branch_target;

    ex_mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .store_data     (store_data),
        .pc_plus4       (pc_plus4),
        .branch_offset  (branch_offset),
        .dest_reg       (dest_reg),
        .ctl_in         (ctl_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_dest_reg   (out_dest_reg),
        .out_ctl        (out_ctl),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] sd;
        logic [4:0]  dr;
        logic [3:0]  ctl;
    } exp_t;

    exp_t        sb[$];
    int          occ;
    bit          br_exp;
    logic [31:0] tgt_exp;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two; a beat enters when
    // fewer than two are held; the branch rule is applied to accepted beats.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            occ = 0;
            sb.delete();
            br_exp = 1'b0;
        end else begin : mdl
            bit   acc;
            bit   drn;
            bit   tk;
            exp_t e;
            acc = in_valid && (occ < 2) && !flush;
            drn = (occ > 0) && out_ready;
            tk  = (ctl_in[5] && alu_zero) || (ctl_in[4] && !alu_zero);
            br_exp = acc && tk;
            if (acc) tgt_exp = pc_plus4 + branch_offset * 32'd4;
            if (flush) begin
                occ = 0;
                sb.delete();
            end else begin
                if (drn) occ--;
                if (acc) begin
                    e.result = alu_result;
                    e.sd     = store_data;
                    e.dr     = dest_reg;
                    e.ctl    = ctl_in[3:0];
                    sb.push_back(e);
                    occ++;
                end
            end
        end
    end

    // Monitor: compares DUT outputs with the model and retires drained beats.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(occ > 0));
        chk("in_ready", 32'(in_ready), 32'(occ < 2));
        chk("branch_taken", 32'(branch_taken), 32'(br_exp));
        if (br_exp) chk("branch_target", branch_target, tgt_exp);
        if (occ > 0 && !reset) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: output valid but no expected entry at %0t", $time);
            end else begin
                chk("out_result", out_result, sb[0].result);
                chk("out_store_data", out_store_data, sb[0].sd);
                chk("out_dest_reg", 32'(out_dest_reg), 32'(sb[0].dr));
                chk("out_ctl", 32'(out_ctl), 32'(sb[0].ctl));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] res, input logic [31:0] sd,
                            input logic [31:0] pc, input logic [31:0] off,
                            input logic z, input logic [4:0] dr, input logic [5:0] ctl);
        in_valid      = 1'b1;
        alu_result    = res;
        store_data    = sd;
        pc_plus4      = pc;
        branch_offset = off;
        alu_zero      = z;
        dest_reg      = dr;
        ctl_in        = ctl;
    endtask

    // Holds the presented beat until the edge that accepts it.
    task automatic wait_accept();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 64 cycles at %0t", $time);
        end
    endtask

    task automatic send(input logic [31:0] res, input logic [31:0] sd,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic z, input logic [4:0] dr, input logic [5:0] ctl);
        set_beat(res, sd, pc, off, z, dr, ctl);
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        alu_result = '0;
        alu_zero = 1'b0;
        store_data = '0;
        pc_plus4 = '0;
        branch_offset = '0;
        dest_reg = '0;
        ctl_in = '0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_branch_taken", 32'(branch_taken), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_ctl", 32'(out_ctl), 32'd0);
        chk("rst_branch_target", branch_target, 32'd0);
        reset = 1'b0;
        step();

        // Single beat, one-cycle latency.
        out_ready = 1'b1;
        send(32'h2A, 32'h0, 32'h0, 32'h0, 1'b0, 5'd5, 6'b001000);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", out_result, 32'h2A);
        chk("t1_out_dest_reg", 32'(out_dest_reg), 32'd5);
        chk("t1_out_ctl", 32'(out_ctl), 32'b1000);
        step();

        // Backpressure: A held, B in skid, C waits until room.
        out_ready = 1'b0;
        send(32'h11, 32'hA1, 32'h0, 32'h0, 1'b0, 5'd1, 6'b001000);
        send(32'h22, 32'hA2, 32'h0, 32'h0, 1'b0, 5'd2, 6'b001000);
        set_beat(32'h33, 32'hA3, 32'h0, 32'h0, 1'b0, 5'd3, 6'b001000);
        step();
        step();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_result", out_result, 32'h11);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_accept();
        for (int i = 0; i < 4; i++) step();

        // beq taken, then not taken.
        send(32'h0, 32'h0, 32'h100, 32'h3, 1'b1, 5'd0, 6'b100000);
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_target", branch_target, 32'h10C);
        step();
        chk("beq_pulse_end", 32'(branch_taken), 32'd0);
        send(32'h0, 32'h0, 32'h100, 32'h3, 1'b0, 5'd0, 6'b100000);
        chk("beq_not_taken", 32'(branch_taken), 32'd0);
        step();

        // bne taken with negative offset.
        send(32'h0, 32'h0, 32'h200, 32'hFFFF_FFFE, 1'b0, 5'd0, 6'b010000);
        chk("bne_taken", 32'(branch_taken), 32'd1);
        chk("bne_target", branch_target, 32'h1F8);
        step();

        // Flush with skid full and a taken beq presented.
        out_ready = 1'b0;
        send(32'h44, 32'h0, 32'h0, 32'h0, 1'b0, 5'd4, 6'b000100);
        send(32'h55, 32'h0, 32'h0, 32'h0, 1'b0, 5'd6, 6'b000110);
        chk("fl_skid_full", 32'(in_ready), 32'd0);
        set_beat(32'h66, 32'h0, 32'h100, 32'h3, 1'b1, 5'd7, 6'b100000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_no_pulse", 32'(branch_taken), 32'd0);
        step();

        // Asynchronous reset during backpressure with a pulse in flight.
        send(32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 5'd8, 6'b001000);
        send(32'h88, 32'h0, 32'h300, 32'h1, 1'b0, 5'd9, 6'b011000);
        chk("ar_pre_pulse", 32'(branch_taken), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_branch_taken", 32'(branch_taken), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_out_result", out_result, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("ar_post_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 31) == 0);
            alu_result    = $urandom;
            store_data    = $urandom;
            pc_plus4      = $urandom;
            branch_offset = $urandom;
            alu_zero      = 1'($urandom);
            dest_reg      = 5'($urandom);
            ctl_in        = 6'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("final_drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU. Captures the ALU result, the zero flag and the forwarded control/data fields into the EX/MEM boundary.
- Resolves conditional branches (beq/bne) from the zero flag and computes the branch target.
- Decouples EX from MEM with a valid/ready handshake and a 2-entry skid buffer, so that in_ready is a registered signal.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, PC).
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held and incoming entries.
- in_valid  input  1  EX presents an instruction.
- in_ready  output  1  stage can accept this cycle (registered).
- alu_result  input  DATA_W  ALU result.
- alu_zero  input  1  ALU zero flag.
- store_data  input  DATA_W  rt value for stores.
- pc_plus4  input  DATA_W  PC+4 of the instruction.
- branch_offset  input  DATA_W  sign-extended immediate, in words.
- dest_reg  input  REG_W  writeback register index.
- ctl_in  input  6  {branch_eq, branch_ne, regwrite, memread, memwrite, memtoreg}.
- out_valid  output  1  MEM-side entry valid.
- out_ready  input  1  MEM accepts.
- out_result  output  DATA_W  registered alu_result.
- out_store_data  output  DATA_W  registered store_data.
- out_dest_reg  output  REG_W  registered dest_reg.
- out_ctl  output  4  {regwrite, memread, memwrite, memtoreg}.
- branch_taken  output  1  one-cycle pulse: branch resolved taken.
- branch_target  output  DATA_W  pc_plus4 + (branch_offset << 2), valid while branch_taken=1.

Behaviour:
- Reset (asynchronous, active-high):
  - Valid flags: out_valid=0, skid valid=0, so in_ready=1 once reset is deasserted.
  - branch_taken=0.
  - All data outputs and the skid contents are 0.
- Accept: in_valid && in_ready && !flush.
- Drain: out_valid && out_ready.
- Storage is two slots, main (drives the out_* ports) and skid.
  - in_ready = !skid_valid, registered.
  - Accept, main empty or draining, skid empty: the data loads into main. Latency is 1 cycle from accept to out_valid.
  - Accept while main is held (out_ready=0): the data loads into skid. in_ready falls the next cycle.
  - Drain with skid full: skid moves to main and skid becomes empty. in_ready rises the next cycle.
  - Drain and accept in the same cycle with skid empty: main is replaced by the new entry and out_valid stays 1.
- Order is preserved. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, the out_* ports hold stable.
- Branch resolution is evaluated at accept:
  - taken = (branch_eq && alu_zero) || (branch_ne && !alu_zero).
  - branch_taken is registered: it pulses high for exactly 1 cycle after the accepting edge, independent of out_ready.
  - branch_target is registered in the same cycle as branch_taken.
  - The target addition wraps modulo 2^DATA_W; the shifted-out offset bits are discarded.
  - If both branch_eq and branch_ne are 1, taken=1 (the condition is always true).
- A branch instruction still enters the pipeline and is forwarded to MEM with its regwrite/memread/memwrite fields unchanged. Clearing them is the decoder's job.
- flush (synchronous, highest priority):
  - The next edge clears main and skid valids. The incoming beat is not accepted.
  - No branch_taken pulse is produced for a beat presented in the flush cycle.
  - A branch_taken pulse already registered from the previous cycle still appears.
  - in_ready=1 the cycle after the flush.
- Reset asserted mid-operation: immediate clear, same values as the reset state. Data in flight is lost.
- Invalid entries never assert out_valid. out_* data is don't-care when out_valid=0, but stays deterministic because data registers only load on accept or shift.

Decomposition:
- Shared package nucore_pkg:
  - DATA_W and REG_W constants.
  - Packed memory/writeback control struct {regwrite, memread, memwrite, memtoreg} and its width constant.
  - Branch control bit positions within ctl_in.
- One natural sub-module: branch_resolve (combinational). Takes the zero flag, branch_eq/ne, pc_plus4 and offset; outputs taken and target. It is reusable by a future early-branch unit.
- The skid buffer stays inline.

Test Plan:
- Reset then in_valid=1 with alu_result=0x0000_002A, dest_reg=5, ctl regwrite=1, out_ready=1 -> next cycle out_valid=1, out_result=0x2A, out_dest_reg=5, out_ctl=4'b1000.
- Backpressure: out_ready=0, issue A=0x11, B=0x22, C=0x33 back-to-back -> A held on the outputs. in_ready=0 after B is accepted, so C is not accepted. Raise out_ready -> outputs A, then B, then C, in order with no loss.
- beq: alu_zero=1, pc_plus4=0x100, branch_offset=0x3 -> one cycle after accept, branch_taken=1 for 1 cycle with branch_target=0x10C. Same stimulus with alu_zero=0 -> no pulse.
- bne: alu_zero=0, pc_plus4=0x200, branch_offset=0xFFFF_FFFE -> branch_taken=1 with branch_target=0x1F8. Also checks wrap and negative offset.
- Flush with skid full and a taken beq presented in the same cycle -> next cycle out_valid=0, in_ready=1, and no branch_taken pulse.
- Assert reset asynchronously mid-backpressure -> out_valid, branch_taken and the skid valid clear immediately without waiting for a clock edge. in_ready=1 after reset deasserts.
